keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
// - Scans the 4x3 phone keypad (1-9, *, 0, #), debounces it and reports one
//   accepted key at a time.
// - Sits directly upstream of the word-length counter:
//   - digit_held drives that counter's clk input (high while a non-star key is held).
//   - star_held drives its is_star_pressed input.
// - key_code/key_valid feed the character-entry logic.
// PARAMETERS
// - SCAN_DIV         5000  clocks each column is driven (dwell); must be >= 4
// - DEBOUNCE_FRAMES  4     consecutive identical scan frames needed to accept a change; >= 2
// PORTS
// - clk         in   1  system clock
// - reset       in   1  synchronous, active-high reset
// - row_n       in   4  keypad rows, active-low (pulled up), asynchronous to clk
// - col_n       out  3  column drive, active-low one-hot
// - key_code    out  4  accepted key: 0-9 = digits, A = *, B = #, F = none
// - key_valid   out  1  one-cycle pulse when a new key is accepted
// - digit_held  out  1  debounced level: accepted key is a digit or #
// - star_held   out  1  debounced level: accepted key is *
// BEHAVIOUR
// - Clocking: one clock (clk); reset is synchronous and active-high, sampled on posedge clk.
// - Reset values:
//   - col_n = 3'b110 (column 0 driven); key_code = 4'hF.
//   - key_valid = digit_held = star_held = 0.
//   - All counters 0; state RELEASED.
//   - Reset mid-press drops all outputs the next cycle; a held key must re-debounce.
// - Synchronizer: row_n passes through a 2-FF synchronizer before any use.
// - Scan:
//   - Dwell counter runs 0..SCAN_DIV-1; on SCAN_DIV-1 it wraps and col_n rotates 110->101->011->110.
//   - Synchronized rows are sampled on dwell count SCAN_DIV-1 of each column.
//     (Settling + sync delay are covered because SCAN_DIV >= 4.)
//   - One frame = 3 columns = 3*SCAN_DIV clocks.
// - Frame result:
//   - Key map (row,col): r0 = 1 2 3; r1 = 4 5 6; r2 = 7 8 9; r3 = * 0 #.
//   - Result is the first pressed key in order col0..col2, row0..row3, else F.
//   - Multiple keys resolve to the lowest index; no error flag.
// - Debounce (per frame end):
//   - If result == candidate, stable_cnt increments, saturating at DEBOUNCE_FRAMES-1.
//   - Otherwise candidate <= result and stable_cnt <= 0.
//   - Accept when stable_cnt reaches DEBOUNCE_FRAMES-1 and candidate != key_code.
// - FSM (2 states):
//   - RELEASED: key_code = F.
//     - Accepting a key: -> HELD, key_code <= candidate, key_valid pulses 1 cycle.
//   - HELD:
//     - Accepting F -> RELEASED, key_code <= F, no pulse.
//     - Accepting a different key (roll-over without stable release): stay HELD,
//       update key_code and pulse key_valid. digit_held/star_held follow the new key
//       the same cycle. A digit->digit roll-over therefore does NOT make a falling
//       edge on digit_held; the downstream counter sees one press.
// - Outputs:
//   - digit_held = (key_code <= 9) | (key_code == B); star_held = (key_code == A).
//   - Both are registered, change only on accept, and are never high together.
// - Latency:
//   - Press stable from frame start -> accepted at end of frame DEBOUNCE_FRAMES,
//     i.e. <= (DEBOUNCE_FRAMES+1)*3*SCAN_DIV + 3 clocks.
//   - Release has the same latency.
//   - Bounces shorter than DEBOUNCE_FRAMES frames produce no output change.
// - Counters: dwell counter is $clog2(SCAN_DIV) bits; stable_cnt is $clog2(DEBOUNCE_FRAMES) bits.
//   Neither ever wraps past its terminal value.
// STRUCTURE
// - keypad_pkg holds:
//   - KEY_STAR = 4'hA, KEY_HASH = 4'hB, KEY_NONE = 4'hF;
//   - NUM_ROWS = 4, NUM_COLS = 3;
//   - the row/col -> code lookup function.
// - Sub-module keypad_debounce: candidate reg, stable_cnt and accept strobe; generic
//   4-bit value input plus frame_tick.
// - Top level holds the synchronizer, column scan, frame encode, FSM and output regs.
// TESTING (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame = 12 clk)
// - Reset held 3 clk -> col_n=110, key_code=F, all flags 0; col_n rotates every 4 clk after release.
// - Hold key 5 (row1 low while col1 driven) steady -> exactly one key_valid pulse with
//   key_code=5, digit_held=1 within 48 clk; release -> digit_held=0 within 48 clk, no pulse.
// - Hold * -> star_held=1, key_code=A, digit_held=0; release, then # -> digit_held=1, key_code=B.
// - Key 8 bouncing (toggling every frame for 2 frames), then stable -> single pulse,
//   key_code=8; no output change during bounce.
// - Keys 1 and 9 held together -> key_code=1; roll 1 -> 2 without release ->
//   second pulse, key_code=2, digit_held stays 1 throughout.
// - Assert reset while key 0 is held and accepted -> outputs cleared next clk;
//   key 0 re-accepted 36-48 clk after reset deasserts.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, FSM state type and the keypad position-to-code
// lookup for the 4x3 phone keypad scanner.
//   Codes: 0-9 digits, KEY_STAR (*), KEY_HASH (#), KEY_NONE (no key).
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'hF;

    typedef enum logic {
        RELEASED = 1'b0,
        HELD     = 1'b1
    } scan_state_t;

    // Layout: r0 = 1 2 3, r1 = 4 5 6, r2 = 7 8 9, r3 = * 0 #
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        int idx;
        if (row == 2'd3) begin
            case (col)
                2'd0:    key_lookup = KEY_STAR;
                2'd1:    key_lookup = 4'h0;
                default: key_lookup = KEY_HASH;
            endcase
        end else begin
            idx        = int'(row) * 3 + int'(col) + 1;
            key_lookup = 4'(idx);
        end
    endfunction

    // Keys that clock the downstream word-length counter: digits and '#'.
    function automatic logic is_digit_or_hash(input logic [3:0] code);
        return (code <= 4'd9) || (code == KEY_HASH);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: bundles the keypad matrix lines and the accepted-key outputs.
//   row_n      keypad rows, active-low, driven by the keypad (asynchronous)
//   col_n      column drive, active-low one-hot, driven by the scanner
//   key_code   accepted key code (KEY_NONE when released)
//   key_valid  one-cycle pulse on each newly accepted key
//   digit_held level: accepted key is a digit or '#'
//   star_held  level: accepted key is '*'
// Modports: master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row_n;
    logic [NUM_COLS-1:0] col_n;
    logic [3:0]          key_code;
    logic                key_valid;
    logic                digit_held;
    logic                star_held;

    modport master (
        input  row_n,
        output col_n, key_code, key_valid, digit_held, star_held
    );

    modport slave (
        output row_n,
        input  col_n, key_code, key_valid, digit_held, star_held
    );

endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-rate debouncer for a 4-bit code.
//   clk, reset   system clock, synchronous active-high reset
//   frame_tick   one-cycle strobe carrying a new frame result on 'value'
//   value        frame result code
//   current      code currently accepted downstream
//   candidate    code being qualified
//   accept       one-cycle strobe: candidate has been stable long enough and
//                differs from 'current'
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [3:0] value,
    input  logic [3:0] current,
    output logic [3:0] candidate,
    output logic       accept
);

    localparam int             CW      = $clog2(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_FRAMES - 1);

    logic [CW-1:0] stable_cnt;
    logic [CW-1:0] cnt_next;
    logic          match;

    // NOTE: every signal assigned in always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_next = '0;
        match    = (value == candidate);
        if (match) begin
            cnt_next = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            candidate  <= KEY_NONE;
            stable_cnt <= '0;
            accept     <= 1'b0;
        end else begin
            accept <= 1'b0;
            if (frame_tick) begin
                candidate  <= value;
                stable_cnt <= cnt_next;
                // Fires on the frame the count reaches its terminal value; once
                // accepted, 'current' equals candidate so it cannot re-fire.
                accept     <= match && (cnt_next == CNT_MAX) && (candidate != current);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 phone keypad, debounces it and reports one
// accepted key at a time.
//   clk     system clock
//   reset   synchronous, active-high reset
//   kp      keypad_scanner_if.master: row_n in, col_n/key_code/key_valid/
//           digit_held/star_held out
// Each column is driven for SCAN_DIV clocks; rows are sampled on the last
// dwell clock. A frame (3 columns) yields the lowest-index pressed key, which
// is debounced over DEBOUNCE_FRAMES frames before the FSM accepts it.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 5000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);

    localparam int            DW        = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [1:0]    LAST_COL  = 2'(NUM_COLS - 1);

    // Synchronizer
    logic [NUM_ROWS-1:0] row_meta;
    logic [NUM_ROWS-1:0] row_sync;

    // Scan / frame encode
    logic [DW-1:0]       dwell;
    logic [NUM_COLS-1:0] col_n_q;
    logic [1:0]          col_idx;
    logic [3:0]          frame_acc;
    logic [3:0]          frame_value;
    logic                frame_tick;
    logic [3:0]          col_hit;
    logic [3:0]          merged;
    logic                last_dwell;
    logic                last_col;

    // Debounce / FSM
    logic [3:0]          candidate;
    logic                accept;
    scan_state_t         state;
    scan_state_t         state_next;
    logic [3:0]          key_code_q;
    logic [3:0]          code_next;
    logic                key_valid_q;
    logic                valid_next;
    logic                digit_held_q;
    logic                star_held_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= kp.row_n;
            row_sync <= row_meta;
        end
    end

    assign last_dwell = (dwell == DWELL_MAX);
    assign last_col   = (col_idx == LAST_COL);

    // Lowest pressed row in the current column; scanning downward lets the
    // lowest index overwrite higher ones.
    always_comb begin
        col_hit = KEY_NONE;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row_sync[r]) begin
                col_hit = key_lookup(2'(r), col_idx);
            end
        end
    end

    // Earlier columns win, so a key already found this frame is kept.
    assign merged = (frame_acc != KEY_NONE) ? frame_acc : col_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            dwell       <= '0;
            col_n_q     <= 3'b110;
            col_idx     <= 2'd0;
            frame_acc   <= KEY_NONE;
            frame_value <= KEY_NONE;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (last_dwell) begin
                dwell   <= '0;
                col_n_q <= {col_n_q[1:0], col_n_q[2]};
                col_idx <= last_col ? 2'd0 : col_idx + 2'd1;
                if (last_col) begin
                    frame_value <= merged;
                    frame_tick  <= 1'b1;
                    frame_acc   <= KEY_NONE;
                end else begin
                    frame_acc <= merged;
                end
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .value      (frame_value),
        .current    (key_code_q),
        .candidate  (candidate),
        .accept     (accept)
    );

    always_comb begin
        state_next = state;
        code_next  = key_code_q;
        valid_next = 1'b0;
        if (accept) begin
            case (state)
                RELEASED: begin
                    if (candidate != KEY_NONE) begin
                        state_next = HELD;
                        code_next  = candidate;
                        valid_next = 1'b1;
                    end
                end
                HELD: begin
                    if (candidate == KEY_NONE) begin
                        state_next = RELEASED;
                        code_next  = KEY_NONE;
                    end else begin
                        // Roll-over: level flags follow the new key in the
                        // same cycle, so digit->digit keeps digit_held high.
                        code_next  = candidate;
                        valid_next = 1'b1;
                    end
                end
                default: state_next = RELEASED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RELEASED;
            key_code_q   <= KEY_NONE;
            key_valid_q  <= 1'b0;
            digit_held_q <= 1'b0;
            star_held_q  <= 1'b0;
        end else begin
            state        <= state_next;
            key_code_q   <= code_next;
            key_valid_q  <= valid_next;
            digit_held_q <= is_digit_or_hash(code_next);
            star_held_q  <= (code_next == KEY_STAR);
        end
    end

    assign kp.col_n      = col_n_q;
    assign kp.key_code   = key_code_q;
    assign kp.key_valid  = key_valid_q;
    assign kp.digit_held = digit_held_q;
    assign kp.star_held  = star_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner with
// SCAN_DIV=4, DEBOUNCE_FRAMES=3 (one frame = 12 clocks). A behavioural keypad
// pulls a row low while its pressed key's column is driven.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_FRAMES = 3;
    localparam int FRAME           = 12;
    localparam int SETTLE          = 48;

    // Bit positions in 'pressed' = row*3 + col
    localparam int K1    = 0;
    localparam int K2    = 1;
    localparam int K5    = 4;
    localparam int K8    = 7;
    localparam int K9    = 8;
    localparam int KSTAR = 9;
    localparam int K0    = 10;
    localparam int KHASH = 11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] pressed = '0;
    logic [3:0]  row_model;

    always_comb begin
        row_model = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[r*3 + c] && !kp.col_n[c]) row_model[r] = 1'b0;
            end
        end
    end
    assign kp.row_n = row_model;

    // Event monitors (monotonic; tasks compare deltas)
    int         valid_count = 0;
    int         digit_falls = 0;
    int         out_changes = 0;
    logic       prev_digit  = 1'b0;
    logic [6:0] prev_outs   = 7'h78;

    always @(posedge clk) begin
        if (kp.key_valid === 1'b1) valid_count++;
        if (prev_digit && !kp.digit_held) digit_falls++;
        prev_digit = kp.digit_held;
        if ({kp.key_code, kp.key_valid, kp.digit_held, kp.star_held} !== prev_outs) out_changes++;
        prev_outs = {kp.key_code, kp.key_valid, kp.digit_held, kp.star_held};
    end

    // Lands on the negedge right after a frame boundary (col_n 011 -> 110).
    task automatic align_frame();
        logic [2:0] prev;
        prev = kp.col_n;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (prev == 3'b011 && kp.col_n == 3'b110) return;
            prev = kp.col_n;
        end
        n_cmp++; n_bad++;
        $display("FAIL align_frame: col_n got %b, frame boundary never seen", kp.col_n);
    endtask

    task automatic settle();
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic release_all();
        align_frame();
        pressed = '0;
        settle();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        pressed = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (kp.col_n !== 3'b110) begin n_bad++; $display("FAIL reset_col_n: got %b expected %b", kp.col_n, 3'b110); end
        n_cmp++; if (kp.key_code !== KEY_NONE) begin n_bad++; $display("FAIL reset_key_code: got %h expected %h", kp.key_code, KEY_NONE); end
        n_cmp++; if (kp.key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_key_valid: got %b expected 0", kp.key_valid); end
        n_cmp++; if (kp.digit_held !== 1'b0) begin n_bad++; $display("FAIL reset_digit_held: got %b expected 0", kp.digit_held); end
        n_cmp++; if (kp.star_held !== 1'b0) begin n_bad++; $display("FAIL reset_star_held: got %b expected 0", kp.star_held); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (kp.col_n !== 3'b110) begin n_bad++; $display("FAIL scan_col0_dwell: got %b expected %b", kp.col_n, 3'b110); end
        @(negedge clk);
        n_cmp++; if (kp.col_n !== 3'b101) begin n_bad++; $display("FAIL scan_col1: got %b expected %b", kp.col_n, 3'b101); end
        repeat (4) @(negedge clk);
        n_cmp++; if (kp.col_n !== 3'b011) begin n_bad++; $display("FAIL scan_col2: got %b expected %b", kp.col_n, 3'b011); end
        repeat (4) @(negedge clk);
        n_cmp++; if (kp.col_n !== 3'b110) begin n_bad++; $display("FAIL scan_wrap: got %b expected %b", kp.col_n, 3'b110); end
    endtask

    task automatic test_key5();
        int v0;
        align_frame();
        v0 = valid_count;
        pressed[K5] = 1'b1;
        settle();
        n_cmp++; if (valid_count - v0 != 1) begin n_bad++; $display("FAIL key5_pulses: got %0d expected 1", valid_count - v0); end
        n_cmp++; if (kp.key_code !== 4'h5) begin n_bad++; $display("FAIL key5_code: got %h expected 5", kp.key_code); end
        n_cmp++; if (kp.digit_held !== 1'b1) begin n_bad++; $display("FAIL key5_digit_held: got %b expected 1", kp.digit_held); end
        n_cmp++; if (kp.star_held !== 1'b0) begin n_bad++; $display("FAIL key5_star_held: got %b expected 0", kp.star_held); end
        v0 = valid_count;
        release_all();
        n_cmp++; if (valid_count - v0 != 0) begin n_bad++; $display("FAIL key5_release_pulses: got %0d expected 0", valid_count - v0); end
        n_cmp++; if (kp.digit_held !== 1'b0) begin n_bad++; $display("FAIL key5_release_digit: got %b expected 0", kp.digit_held); end
        n_cmp++; if (kp.key_code !== KEY_NONE) begin n_bad++; $display("FAIL key5_release_code: got %h expected F", kp.key_code); end
    endtask

    task automatic test_star_hash();
        align_frame();
        pressed[KSTAR] = 1'b1;
        settle();
        n_cmp++; if (kp.key_code !== KEY_STAR) begin n_bad++; $display("FAIL star_code: got %h expected A", kp.key_code); end
        n_cmp++; if (kp.star_held !== 1'b1) begin n_bad++; $display("FAIL star_held: got %b expected 1", kp.star_held); end
        n_cmp++; if (kp.digit_held !== 1'b0) begin n_bad++; $display("FAIL star_digit_held: got %b expected 0", kp.digit_held); end
        release_all();
        n_cmp++; if (kp.star_held !== 1'b0) begin n_bad++; $display("FAIL star_release: got %b expected 0", kp.star_held); end
        align_frame();
        pressed[KHASH] = 1'b1;
        settle();
        n_cmp++; if (kp.key_code !== KEY_HASH) begin n_bad++; $display("FAIL hash_code: got %h expected B", kp.key_code); end
        n_cmp++; if (kp.digit_held !== 1'b1) begin n_bad++; $display("FAIL hash_digit_held: got %b expected 1", kp.digit_held); end
        n_cmp++; if (kp.star_held !== 1'b0) begin n_bad++; $display("FAIL hash_star_held: got %b expected 0", kp.star_held); end
        release_all();
        n_cmp++; if (kp.key_code !== KEY_NONE) begin n_bad++; $display("FAIL hash_release_code: got %h expected F", kp.key_code); end
    endtask

    task automatic test_bounce();
        int v0;
        int c0;
        align_frame();
        v0 = valid_count;
        c0 = out_changes;
        pressed[K8] = 1'b1;
        repeat (FRAME) @(negedge clk);
        pressed[K8] = 1'b0;
        repeat (FRAME) @(negedge clk);
        pressed[K8] = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        n_cmp++; if (out_changes != c0) begin n_bad++; $display("FAIL bounce_quiet: got %0d output changes expected 0", out_changes - c0); end
        repeat (2 * FRAME) @(negedge clk);
        n_cmp++; if (valid_count - v0 != 1) begin n_bad++; $display("FAIL bounce_pulses: got %0d expected 1", valid_count - v0); end
        n_cmp++; if (kp.key_code !== 4'h8) begin n_bad++; $display("FAIL bounce_code: got %h expected 8", kp.key_code); end
        release_all();
    endtask

    task automatic test_rollover();
        int v0;
        int f0;
        align_frame();
        v0 = valid_count;
        pressed[K1] = 1'b1;
        pressed[K9] = 1'b1;
        settle();
        n_cmp++; if (kp.key_code !== 4'h1) begin n_bad++; $display("FAIL multi_code: got %h expected 1", kp.key_code); end
        n_cmp++; if (valid_count - v0 != 1) begin n_bad++; $display("FAIL multi_pulses: got %0d expected 1", valid_count - v0); end
        align_frame();
        v0 = valid_count;
        f0 = digit_falls;
        pressed = '0;
        pressed[K2] = 1'b1;
        settle();
        n_cmp++; if (kp.key_code !== 4'h2) begin n_bad++; $display("FAIL roll_code: got %h expected 2", kp.key_code); end
        n_cmp++; if (valid_count - v0 != 1) begin n_bad++; $display("FAIL roll_pulses: got %0d expected 1", valid_count - v0); end
        n_cmp++; if (digit_falls != f0) begin n_bad++; $display("FAIL roll_digit_fall: got %0d falls expected 0", digit_falls - f0); end
        n_cmp++; if (kp.digit_held !== 1'b1) begin n_bad++; $display("FAIL roll_digit_held: got %b expected 1", kp.digit_held); end
        release_all();
    endtask

    task automatic test_reset_midpress();
        int v0;
        int n;
        align_frame();
        pressed[K0] = 1'b1;
        settle();
        n_cmp++; if (kp.key_code !== 4'h0) begin n_bad++; $display("FAIL held0_code: got %h expected 0", kp.key_code); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (kp.key_code !== KEY_NONE) begin n_bad++; $display("FAIL midreset_code: got %h expected F", kp.key_code); end
        n_cmp++; if (kp.digit_held !== 1'b0) begin n_bad++; $display("FAIL midreset_digit: got %b expected 0", kp.digit_held); end
        n_cmp++; if (kp.col_n !== 3'b110) begin n_bad++; $display("FAIL midreset_col_n: got %b expected %b", kp.col_n, 3'b110); end
        @(negedge clk);
        reset = 1'b0;
        v0 = valid_count;
        n  = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            n = i;
            if (kp.key_code === 4'h0) break;
        end
        n_cmp++; if (kp.key_code !== 4'h0 || n < 36 || n > 48) begin n_bad++; $display("FAIL reaccept_latency: got %0d clk (code %h) expected 36..48 clk", n, kp.key_code); end
        repeat (2) @(negedge clk);
        n_cmp++; if (valid_count - v0 != 1) begin n_bad++; $display("FAIL reaccept_pulses: got %0d expected 1", valid_count - v0); end
        release_all();
    endtask

    initial begin
        test_reset();
        test_key5();
        test_star_hash();
        test_bounce();
        test_rollover();
        test_reset_midpress();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
